// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT sample buffer.
package fft_pkg;

    localparam int BIT_WIDTH_DEF = 16;
    localparam int FRAME_LEN_DEF = 256;

    typedef logic [BIT_WIDTH_DEF-1:0] sample_t;
    typedef logic                     bank_sel_t;

endpackage

// File: rtl/sync_pulse.sv
// Moves a slow strobe into the clk domain: two-flop synchronizer followed by
// a rising-edge detector, so each strobe gives exactly one clk-wide pulse.
module sync_pulse (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse_out
);

    logic sync1;
    logic sync2;
    logic sync3;

    // Synchronizer chain plus one delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign pulse_out = sync2 & ~sync3;

endmodule

// File: rtl/fft_sample_buffer.sv
// Ping-pong frame buffer between the SPI slave (sclk domain) and the FFT core.
// Words are captured on a synchronized strobe, written into the current fill
// bank, and full banks are handed to the FFT in fill order.
module fft_sample_buffer
    import fft_pkg::*;
#(
    parameter  int BIT_WIDTH = BIT_WIDTH_DEF,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 received_wd,
    input  logic [BIT_WIDTH-1:0] sample_in,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [BIT_WIDTH-1:0] rd_data,
    output logic                 frame_ready,
    input  logic                 frame_done,
    output logic [ADDR_W-1:0]    wr_count,
    output logic                 overflow
);

    logic                 wd_pulse;
    logic [BIT_WIDTH-1:0] sample_q;
    logic                 wr_en;

    bank_sel_t            wr_bank;
    bank_sel_t            rd_bank;
    logic [1:0]           bank_full;

    bank_sel_t            wr_bank_nxt;
    bank_sel_t            rd_bank_nxt;
    logic [1:0]           bank_full_nxt;

    logic                 wr_accept;
    logic                 wr_last;
    logic                 rd_release;

    logic [BIT_WIDTH-1:0] mem [0:2*FRAME_LEN-1];

    sync_pulse u_sync_wd (
        .clk       (clk),
        .reset_n   (reset_n),
        .async_in  (received_wd),
        .pulse_out (wd_pulse)
    );

    // Sample bus is quasi-static when the pulse arrives, so it is captured
    // directly without its own synchronizer.
    always_ff @(posedge clk) begin
        if (wd_pulse) begin
            sample_q <= sample_in;
        end
    end

    // Write strobe trails the capture by one cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en <= 1'b0;
        end else begin
            wr_en <= wd_pulse;
        end
    end

    // The full check uses the pre-update flags, so a bank freed by frame_done
    // in this same cycle still rejects the incoming sample.
    assign wr_accept  = wr_en & ~bank_full[wr_bank];
    assign wr_last    = (wr_count == ADDR_W'(FRAME_LEN - 1));
    assign rd_release = frame_done & frame_ready;

    // Next bank state: fill completion and frame release may hit different
    // banks in the same cycle and both apply.
    always_comb begin
        bank_full_nxt = bank_full;
        wr_bank_nxt   = wr_bank;
        rd_bank_nxt   = rd_bank;
        if (wr_accept && wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
            wr_bank_nxt            = ~wr_bank;
        end
        if (rd_release) begin
            bank_full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt            = ~rd_bank;
        end
    end

    // Control state; frame_ready is registered from next-state so it tracks
    // bank_full[rd_bank] without a combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_full   <= 2'b00;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            frame_ready <= 1'b0;
            wr_count    <= '0;
            overflow    <= 1'b0;
        end else begin
            bank_full   <= bank_full_nxt;
            wr_bank     <= wr_bank_nxt;
            rd_bank     <= rd_bank_nxt;
            frame_ready <= bank_full_nxt[rd_bank_nxt];
            if (wr_en && bank_full[wr_bank]) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                wr_count <= wr_last ? '0 : wr_count + ADDR_W'(1);
            end
        end
    end

    // Sample memory write port (no reset so it maps onto block RAM)
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_count}] <= sample_q;
        end
    end

    // Registered read of the ready bank
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: doc/fft_sample_buffer.md
Name: fft_sample_buffer

Overview:
Downstream of the SPI slave. Takes each 16-bit word the SPI slave reports with received_wd/sample_in and moves it from the sclk domain into the system clk domain. Assembles the words into FRAME_LEN-sample frames in a ping-pong (two-bank) buffer. Presents completed frames to the FFT core through a random-access read port with a frame_ready/frame_done handshake.

Parameters:
BIT_WIDTH, 16, sample width; matches the SPI word width.
FRAME_LEN, 256, samples per FFT frame; power of two, ≥ 4.
ADDR_W, $clog2(FRAME_LEN), frame address width; derived, not overridden.

Ports:
clk  in  1  system clock; frequency ≥ 3× sclk.
reset_n  in  1  synchronous active-low reset.
received_wd  in  1  word strobe from SPI slave (sclk domain, high ≥ 1 sclk period).
sample_in  in  BIT_WIDTH  sample from SPI slave (sclk domain, stable ≥ 14 sclk periods after received_wd rises).
rd_addr  in  ADDR_W  FFT read address within the ready frame.
rd_data  out  BIT_WIDTH  sample at rd_addr of the ready bank, 1-cycle latency.
frame_ready  out  1  a complete frame is available to read.
frame_done  in  1  single-cycle pulse from FFT: the ready frame is consumed.
wr_count  out  ADDR_W  samples written into the current fill bank.
overflow  out  1  sticky: a sample was dropped because both banks were full.

Behaviour:
- Reset, sampled on posedge clk while reset_n=0:
  - rd_data=0, frame_ready=0, wr_count=0, overflow=0.
  - wr_bank=0, rd_bank=0, bank_full=2'b00.
  - Synchronizer flops are cleared. Memory contents are don't-care.
  - Reset mid-frame discards the partial frame and any ready frame.
- CDC:
  - received_wd passes through a 2-flop synchronizer, then a rising-edge detector on the synchronized signal, giving wd_pulse (one clk cycle).
  - On wd_pulse, sample_in is registered into sample_q. It is a multi-bit bus and is not synchronized; stability is guaranteed by the SPI timing above.
  - Latency is 3 clk cycles from the received_wd rise to the sample_q load.
  - A received_wd held high for several clk cycles yields exactly one wd_pulse.
- Write side, one cycle after the sample_q load (write strobe wr_en):
  - If bank_full[wr_bank]=1: drop the sample, set overflow=1, leave wr_count unchanged.
  - Otherwise: mem[wr_bank][wr_count] <= sample_q.
    - If wr_count==FRAME_LEN-1: set bank_full[wr_bank]=1, toggle wr_bank, wr_count <= 0 (wrap).
    - Else: wr_count <= wr_count+1.
- Read side:
  - frame_ready = bank_full[rd_bank], registered as state (no combinational path from inputs).
  - rd_data <= mem[rd_bank][rd_addr] every cycle. Valid data is guaranteed only while frame_ready=1.
  - frame_done with frame_ready=1: clear bank_full[rd_bank], toggle rd_bank. frame_ready drops the next cycle unless the other bank is already full, in which case it stays 1 and the next frame is served.
  - frame_done with frame_ready=0: ignored.
- Simultaneous events:
  - Frame completion on wr_bank and frame_done on rd_bank (different banks) in the same cycle: both take effect.
  - wr_en into a full bank in the same cycle that frame_done frees that same bank: the sample is dropped and overflow is set, because the full check uses pre-update state.
- Ordering: frames are delivered strictly in fill order. Banks alternate 0,1,0,1…
- overflow clears only on reset.

Decomposition:
- Package fft_pkg:
  - BIT_WIDTH and FRAME_LEN defaults.
  - typedef sample_t (logic [BIT_WIDTH-1:0]).
  - typedef bank_sel_t (1 bit).
- Sub-module sync_pulse:
  - 2-flop synchronizer plus rising-edge detect.
  - Ports: clk, reset_n, async_in, pulse_out.
  - Reused for any other sclk→clk strobe.
- Memory is an inferred 2×FRAME_LEN array with a registered read (EBR-friendly).

Test Plan (FRAME_LEN=8):
- Send 8 words 0x0001..0x0008 at sclk=clk/4 → frame_ready rises 1 cycle after the 8th write. rd_addr 0..7 returns 0x0001..0x0008 with 1-cycle latency. wr_count=0, overflow=0.
- Send 16 words 0x0010..0x001F with no frame_done → frame_ready=1, bank0 holds 0x0010..0x0017. Pulse frame_done → rd_data reads 0x0018..0x001F, frame_ready stays 1. Second frame_done → frame_ready=0.
- Send 17 words with no frame_done → 17th word (0x00AA) is dropped, overflow=1 and stays 1 through later frame_done pulses, wr_count=0.
- Hold received_wd high for 10 clk cycles → exactly one write, wr_count 0→1.
- Assert reset_n=0 for 1 cycle after 5 words → wr_count=0, frame_ready=0, overflow=0. Next 8 words form a complete frame in bank0.
- Send frame_done while frame_ready=0 → no state change. Then complete the 8th write of bank1 in the same cycle as frame_done for bank0 → bank0 freed, bank1 full, frame_ready stays 1 with rd_bank=1.
